// File: rtl/irrigation_countdown.sv
// mm:ss BCD down-counter driving an irrigation valve; counts prescaled 1 Hz ticks
// while running and pulses done for one cycle when it reaches 00:00.
module irrigation_countdown #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] preset_min_t,
  input  logic [3:0] preset_min_u,
  input  logic [2:0] preset_sec_t,
  input  logic [3:0] preset_sec_u,
  output logic [3:0] min_t,
  output logic [3:0] min_u,
  output logic [2:0] sec_t,
  output logic [3:0] sec_u,
  output logic       valve_on,
  output logic       paused,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

  state_t      r_state;
  logic [3:0]  r_min_t, r_min_u, r_sec_u;
  logic [2:0]  r_sec_t;
  logic [15:0] r_pre;
  logic        r_valve_on, r_paused, r_done;

  logic [3:0]  w_ld_min_t, w_ld_min_u, w_ld_sec_u;
  logic [2:0]  w_ld_sec_t;
  logic [3:0]  w_dec_min_t, w_dec_min_u, w_dec_sec_u;
  logic [2:0]  w_dec_sec_t;
  logic        w_borrow_su, w_borrow_st, w_borrow_mu;
  logic        w_count_zero, w_dec_zero, w_pre_wrap;

  // Out-of-range preset digits saturate to the largest legal digit.
  assign w_ld_min_t = (preset_min_t > 4'd9) ? 4'd9 : preset_min_t;
  assign w_ld_min_u = (preset_min_u > 4'd9) ? 4'd9 : preset_min_u;
  assign w_ld_sec_t = (preset_sec_t > 3'd5) ? 3'd5 : preset_sec_t;
  assign w_ld_sec_u = (preset_sec_u > 4'd9) ? 4'd9 : preset_sec_u;

  always_comb begin
    w_borrow_su = (r_sec_u == 4'd0);
    w_dec_sec_u = w_borrow_su ? 4'd9 : (r_sec_u - 4'd1);
    w_borrow_st = w_borrow_su && (r_sec_t == 3'd0);
    w_dec_sec_t = r_sec_t;
    if (w_borrow_su) w_dec_sec_t = (r_sec_t == 3'd0) ? 3'd5 : (r_sec_t - 3'd1);
    w_borrow_mu = w_borrow_st && (r_min_u == 4'd0);
    w_dec_min_u = r_min_u;
    if (w_borrow_st) w_dec_min_u = (r_min_u == 4'd0) ? 4'd9 : (r_min_u - 4'd1);
    w_dec_min_t = w_borrow_mu ? (r_min_t - 4'd1) : r_min_t;
  end

  assign w_count_zero = (r_min_t == 4'd0) && (r_min_u == 4'd0) &&
                        (r_sec_t == 3'd0) && (r_sec_u == 4'd0);
  assign w_dec_zero   = (w_dec_min_t == 4'd0) && (w_dec_min_u == 4'd0) &&
                        (w_dec_sec_t == 3'd0) && (w_dec_sec_u == 4'd0);
  assign w_pre_wrap   = (r_pre == PRE_LAST);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_min_t    <= 4'd0;
      r_min_u    <= 4'd0;
      r_sec_t    <= 3'd0;
      r_sec_u    <= 4'd0;
      r_pre      <= 16'd0;
      r_valve_on <= 1'b0;
      r_paused   <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A load issued while running is dropped, so lower-priority inputs still apply.
      if (load && (r_state != S_RUN)) begin
        r_state    <= S_IDLE;
        r_min_t    <= w_ld_min_t;
        r_min_u    <= w_ld_min_u;
        r_sec_t    <= w_ld_sec_t;
        r_sec_u    <= w_ld_sec_u;
        r_pre      <= 16'd0;
        r_valve_on <= 1'b0;
        r_paused   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_count_zero) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state    <= S_RUN;
                r_valve_on <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (stop) begin
              r_state    <= S_PAUSE;
              r_pre      <= 16'd0;
              r_valve_on <= 1'b0;
              r_paused   <= 1'b1;
            end else if (tick) begin
              if (w_pre_wrap) begin
                r_pre   <= 16'd0;
                r_min_t <= w_dec_min_t;
                r_min_u <= w_dec_min_u;
                r_sec_t <= w_dec_sec_t;
                r_sec_u <= w_dec_sec_u;
                if (w_dec_zero) begin
                  r_state    <= S_DONE;
                  r_valve_on <= 1'b0;
                  r_done     <= 1'b1;
                end
              end else begin
                r_pre <= r_pre + 16'd1;
              end
            end
          end
          S_PAUSE: begin
            if (start) begin
              r_state    <= S_RUN;
              r_valve_on <= 1'b1;
              r_paused   <= 1'b0;
            end
          end
          S_DONE: begin
          end
          default: begin
            r_state    <= S_IDLE;
            r_valve_on <= 1'b0;
            r_paused   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign min_t    = r_min_t;
  assign min_u    = r_min_u;
  assign sec_t    = r_sec_t;
  assign sec_u    = r_sec_u;
  assign valve_on = r_valve_on;
  assign paused   = r_paused;
  assign done     = r_done;

endmodule

// File: tb/tb_irrigation_countdown.sv
// Scoreboard bench for irrigation_countdown: two instances (TICK_DIV 1 and 3) share
// stimulus; a seconds-count reference model predicts every cycle's outputs.
module tb_irrigation_countdown;

  // Handshake: every driven cycle pushes one expected word; the monitor pops one
  // word 1 ns after each rising edge while the queue is non-empty.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear, tick, load, start, stop;
  logic [3:0] preset_min_t, preset_min_u, preset_sec_u;
  logic [2:0] preset_sec_t;

  logic [3:0] a_min_t, a_min_u, a_sec_u, b_min_t, b_min_u, b_sec_u;
  logic [2:0] a_sec_t, b_sec_t;
  logic       a_valve, a_paused, a_done, b_valve, b_paused, b_done;

  irrigation_countdown #(.TICK_DIV(1)) dut1 (
    .clk(clk), .clear(clear), .tick(tick), .load(load), .start(start), .stop(stop),
    .preset_min_t(preset_min_t), .preset_min_u(preset_min_u),
    .preset_sec_t(preset_sec_t), .preset_sec_u(preset_sec_u),
    .min_t(a_min_t), .min_u(a_min_u), .sec_t(a_sec_t), .sec_u(a_sec_u),
    .valve_on(a_valve), .paused(a_paused), .done(a_done)
  );

  irrigation_countdown #(.TICK_DIV(3)) dut3 (
    .clk(clk), .clear(clear), .tick(tick), .load(load), .start(start), .stop(stop),
    .preset_min_t(preset_min_t), .preset_min_u(preset_min_u),
    .preset_sec_t(preset_sec_t), .preset_sec_u(preset_sec_u),
    .min_t(b_min_t), .min_u(b_min_u), .sec_t(b_sec_t), .sec_u(b_sec_u),
    .valve_on(b_valve), .paused(b_paused), .done(b_done)
  );

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_state [2];
  int m_total [2];
  int m_pre   [2];
  bit m_done  [2];
  int m_div   [2] = '{1, 3};

  logic [35:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [17:0] model_word(input int i);
    logic [3:0] mt, mu, su;
    logic [2:0] st;
    mt = 4'(m_total[i] / 600);
    mu = 4'((m_total[i] / 60) % 10);
    st = 3'((m_total[i] % 60) / 10);
    su = 4'(m_total[i] % 10);
    return {mt, mu, st, su, (m_state[i] == M_RUN), (m_state[i] == M_PAUSE), m_done[i]};
  endfunction

  function automatic logic [35:0] dut_word();
    return {a_min_t, a_min_u, a_sec_t, a_sec_u, a_valve, a_paused, a_done,
            b_min_t, b_min_u, b_sec_t, b_sec_u, b_valve, b_paused, b_done};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = M_IDLE; m_total[i] = 0; m_pre[i] = 0; m_done[i] = 1'b0;
    end
  endtask

  task automatic model_step(input bit ld, input bit sp, input bit stt, input bit tk,
                            input int pmt, input int pmu, input int pst, input int psu);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (ld && m_state[i] != M_RUN) begin
        m_total[i] = clamp(pmt, 9) * 600 + clamp(pmu, 9) * 60 + clamp(pst, 5) * 10 + clamp(psu, 9);
        m_pre[i]   = 0;
        m_state[i] = M_IDLE;
      end else if (m_state[i] == M_IDLE) begin
        if (stt) begin
          m_state[i] = (m_total[i] == 0) ? M_DONE : M_RUN;
          m_done[i]  = (m_total[i] == 0);
        end
      end else if (m_state[i] == M_RUN) begin
        if (sp) begin
          m_state[i] = M_PAUSE;
          m_pre[i]   = 0;
        end else if (tk) begin
          m_pre[i]++;
          if (m_pre[i] == m_div[i]) begin
            m_pre[i] = 0;
            m_total[i]--;
            if (m_total[i] == 0) begin
              m_state[i] = M_DONE;
              m_done[i]  = 1'b1;
            end
          end
        end
      end else if (m_state[i] == M_PAUSE) begin
        if (stt) m_state[i] = M_RUN;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit ld, input bit sp, input bit stt, input bit tk,
                       input int pmt, input int pmu, input int pst, input int psu);
    @(negedge clk);
    load = ld; stop = sp; start = stt; tick = tk;
    preset_min_t = 4'(pmt); preset_min_u = 4'(pmu);
    preset_sec_t = 3'(pst); preset_sec_u = 4'(psu);
    model_step(ld, sp, stt, tk, pmt, pmu, pst, psu);
    exp_q.push_back({model_word(0), model_word(1)});
  endtask

  task automatic do_load(input int pmt, input int pmu, input int pst, input int psu);
    drive(1, 0, 0, 0, pmt, pmu, pst, psu);
  endtask

  task automatic do_start();
    drive(0, 0, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_stop();
    drive(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [35:0] e;
      logic [35:0] g;
      e = exp_q.pop_front();
      g = dut_word();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, g, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    clear = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    preset_min_t = 4'd0; preset_min_u = 4'd0; preset_sec_t = 3'd0; preset_sec_u = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (dut_word() !== 36'h0) begin
      errors++;
      $display("FAIL reset_state got=%h expected=%h", dut_word(), 36'h0);
    end
    clear = 1'b0;

    // clear while running at 03:27 takes effect without a clock edge
    do_load(0, 3, 2, 7);
    do_start();
    ticks(2);
    @(negedge clk);
    #2 clear = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_word() !== 36'h0) begin
      errors++;
      $display("FAIL async_clear got=%h expected=%h", dut_word(), 36'h0);
    end
    @(negedge clk);
    clear = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    idle(3);

    // 01:00 run-out with TICK_DIV=1
    do_load(0, 1, 0, 0);
    do_start();
    ticks(1);
    ticks(59);
    idle(2);
    ticks(190);
    idle(2);

    // 10:00 -> 09:59 borrow through all digits
    do_load(1, 0, 0, 0);
    do_start();
    ticks(1);
    do_stop();
    ticks(3);

    // pause and resume
    do_load(0, 0, 0, 5);
    do_start();
    ticks(2);
    do_stop();
    ticks(3);
    do_start();
    ticks(3);
    ticks(12);
    idle(2);

    // clamping, then zero preset start
    do_load(12, 3, 7, 15);
    idle(1);
    do_load(0, 0, 0, 0);
    do_start();
    idle(2);
    do_start();
    idle(1);

    // prescaler, load ignored in RUN, stop+start together
    do_load(0, 0, 0, 2);
    do_start();
    ticks(2);
    ticks(1);
    drive(1, 0, 0, 1, 5, 5, 5, 5);
    drive(0, 1, 1, 1, 0, 0, 0, 0);
    ticks(2);
    do_start();
    ticks(4);
    idle(2);

    // randomized phase
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 2)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end
    idle(1);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
